// File: rtl/btn_conditioner.sv
// Button conditioner: synchronises a raw button pin, debounces it, and
// produces a clean pressed level plus press, release and auto-repeat pulses.
// Every output comes straight from a flop; btn never reaches an output
// through combinational logic.
module btn_conditioner #(
   parameter bit BTN_ACTIVE_LOW  = 1'b0,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int HOLD_CYCLES     = 12500000,
   parameter int REPEAT_CYCLES   = 2500000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn,
   output logic       btn_level,
   output logic       press_pulse,
   output logic       release_pulse,
   output logic       repeat_pulse,
   output logic       hold_active,
   output logic [1:0] dbg_state
);

   localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HC_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int HC_W   = $clog2(HC_MAX + 1);

   localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
   localparam logic [HC_W-1:0] REP_LAST  = HC_W'(REPEAT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRESS = 2'd1,
      HOLD  = 2'd2
   } state_t;

   // Handshake note: this block has no valid/ready interfaces; every output
   // is a level or a single-cycle strobe, sampled by the consumer on posedge.

   logic            sync1;
   logic            s_btn;
   logic            db_level;
   logic [DB_W-1:0] db_cnt;

   state_t          state, state_n;
   logic [HC_W-1:0] hold_cnt, hold_cnt_n;
   logic            press_n, release_n, repeat_n, hold_n;

   assign dbg_state = state;

   // Two-flop synchroniser; polarity is normalised before the first flop so
   // everything downstream sees 1 = pressed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         s_btn <= 1'b0;
      end else begin
         sync1 <= btn ^ BTN_ACTIVE_LOW;
         s_btn <= sync1;
      end
   end

   // Debounce: the accepted level flips only after s_btn has disagreed with it
   // for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts the run.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         db_level <= 1'b0;
         db_cnt   <= '0;
      end else if (s_btn == db_level) begin
         db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
         db_level <= ~db_level;
         db_cnt   <= '0;
      end else begin
         db_cnt <= db_cnt + 1'b1;
      end
   end

   // Next-state and next-output logic; a release always takes priority over a
   // repeat that would otherwise fire in the same cycle.
   always_comb begin
      state_n    = state;
      hold_cnt_n = hold_cnt;
      press_n    = 1'b0;
      release_n  = 1'b0;
      repeat_n   = 1'b0;
      hold_n     = hold_active;
      if (!db_level && (state != IDLE)) begin
         state_n    = IDLE;
         hold_cnt_n = '0;
         release_n  = 1'b1;
         hold_n     = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (db_level) begin
                  state_n    = PRESS;
                  hold_cnt_n = '0;
                  press_n    = 1'b1;
               end
            end
            PRESS: begin
               if (hold_cnt == HOLD_LAST) begin
                  state_n    = HOLD;
                  hold_cnt_n = '0;
                  repeat_n   = 1'b1;
                  hold_n     = 1'b1;
               end else begin
                  hold_cnt_n = hold_cnt + 1'b1;
               end
            end
            HOLD: begin
               if (hold_cnt == REP_LAST) begin
                  hold_cnt_n = '0;
                  repeat_n   = 1'b1;
               end else begin
                  hold_cnt_n = hold_cnt + 1'b1;
               end
            end
            default: begin
               state_n    = IDLE;
               hold_cnt_n = '0;
               hold_n     = 1'b0;
            end
         endcase
      end
   end

   // State register and registered outputs; btn_level follows the accepted
   // level in the same cycle as the matching press/release pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         hold_cnt      <= '0;
         btn_level     <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         repeat_pulse  <= 1'b0;
         hold_active   <= 1'b0;
      end else begin
         state         <= state_n;
         hold_cnt      <= hold_cnt_n;
         btn_level     <= db_level;
         press_pulse   <= press_n;
         release_pulse <= release_n;
         repeat_pulse  <= repeat_n;
         hold_active   <= hold_n;
      end
   end

endmodule
